// File: rtl/cpu_gen.sv
// Parametrised multicycle core: shared bus, register file, A/G ALU pair and run/done handshake.
// Instructions are fetched from din in idle; done is combinational from state and opcode.
module cpu_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] bus,
  output logic              done,
  output logic              z
);

  localparam int unsigned IW      = 3 + 2 * REG_AW;
  localparam int unsigned NumRegs = 2 ** REG_AW;
  localparam int unsigned ShW     = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;
  typedef enum logic [2:0] {
    OpMv, OpMvi, OpAdd, OpSub, OpAnd, OpSll, OpMvnz, OpRsv
  } op_e;

  state_e              state_q;
  logic [IW-1:0]       ir_q;
  logic [DATA_W-1:0]   a_q, g_q;
  logic                z_q;
  logic [DATA_W-1:0]   regs_q [NumRegs];

  op_e                 op;
  logic [REG_AW-1:0]   rx, ry;
  logic                is_alu;
  logic [DATA_W-1:0]   alu_res;

  assign op     = op_e'(ir_q[IW-1:IW-3]);
  assign rx     = ir_q[2*REG_AW-1:REG_AW];
  assign ry     = ir_q[REG_AW-1:0];
  assign is_alu = (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpSll);
  assign done   = (state_q == StT3) || ((state_q == StT1) && !is_alu);
  assign z      = z_q;

  // One bus source per state, chosen from state and opcode only.
  always_comb begin
    bus = din;
    unique case (state_q)
      StIdle: bus = din;
      StT1: begin
        case (op)
          OpMvi:                      bus = din;
          OpAdd, OpSub, OpAnd, OpSll: bus = regs_q[rx];
          OpRsv:                      bus = '0;
          default:                    bus = regs_q[ry];
        endcase
      end
      StT2: bus = regs_q[ry];
      StT3: bus = g_q;
      default: bus = din;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = a_q + bus;
      OpSub:   alu_res = a_q - bus;
      OpAnd:   alu_res = a_q & bus;
      OpSll:   alu_res = a_q << bus[ShW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            ir_q    <= din[IW-1:0];
            state_q <= StT1;
          end
        end
        StT1: begin
          case (op)
            OpMv, OpMvi:                regs_q[rx] <= bus;
            OpMvnz:                     if (!z_q) regs_q[rx] <= bus;
            OpAdd, OpSub, OpAnd, OpSll: a_q <= bus;
            default: ;
          endcase
          state_q <= is_alu ? StT2 : StIdle;
        end
        StT2: begin
          g_q     <= alu_res;
          z_q     <= (alu_res == '0);
          state_q <= StT3;
        end
        StT3: begin
          regs_q[rx] <= g_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_gen.sv
// Bench for cpu_gen: directed test-plan programs plus random instructions against an
// architectural model (register array and zero flag), and a 32-bit/16-register build check.
module tb_cpu_gen;

  localparam int OP_MV = 0, OP_MVI = 1, OP_ADD = 2, OP_SUB = 3;
  localparam int OP_AND = 4, OP_SLL = 5, OP_MVNZ = 6, OP_RSV = 7;

  logic        clk = 1'b0;
  logic        resetn, run;
  logic [15:0] din, bus;
  logic        done, z;
  logic        run32;
  logic [31:0] din32, bus32;
  logic        done32, z32;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] mregs [8];
  logic        mz;

  always #5 clk = ~clk;

  cpu_gen #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .resetn(resetn), .run(run), .din(din), .bus(bus), .done(done), .z(z)
  );

  cpu_gen #(.DATA_W(32), .REG_AW(4)) dut32 (
    .clk(clk), .resetn(resetn), .run(run32), .din(din32), .bus(bus32), .done(done32), .z(z32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input int op, input logic [15:0] a, input logic [15:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    case (op)
      OP_ADD:  return 16'((ua + ub) % 65536);
      OP_SUB:  return 16'((ua + 65536 - ub) % 65536);
      OP_AND:  return a & b;
      OP_SLL:  return 16'((ua * (longint'(1) << (ub % 16))) % 65536);
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mz = 1'b0;
  endtask

  // Starts at posedge+1 of an idle cycle, ends at posedge+1 of the following idle cycle.
  task automatic exec(input int op, input int rx, input int ry, input logic [15:0] imm);
    logic [15:0] word, a_v, b_v, res;
    word      = 16'($urandom);
    word[8:6] = op[2:0];
    word[5:3] = rx[2:0];
    word[2:0] = ry[2:0];
    run = 1'b1;
    din = word;
    #1;
    check("idle_bus", bus, word);
    check("idle_done", done, 0);
    @(posedge clk); #1;
    run = 1'($urandom);
    din = (op == OP_MVI) ? imm : 16'($urandom);
    #1;
    if (op >= OP_ADD && op <= OP_SLL) begin
      a_v = mregs[rx];
      check("alu_t1_bus", bus, a_v);
      check("alu_t1_done", done, 0);
      @(posedge clk); #1;
      run = 1'($urandom);
      din = 16'($urandom);
      #1;
      b_v = mregs[ry];
      check("alu_t2_bus", bus, b_v);
      check("alu_t2_done", done, 0);
      res = alu_ref(op, a_v, b_v);
      @(posedge clk); #1;
      run = 1'($urandom);
      #1;
      mregs[rx] = res;
      mz        = (res == 16'h0);
      check("alu_t3_bus", bus, res);
      check("alu_t3_done", done, 1);
      check("alu_t3_z", z, mz);
    end else begin
      case (op)
        OP_MVI: begin
          check("mvi_bus", bus, imm);
          mregs[rx] = imm;
        end
        OP_RSV: check("rsv_bus", bus, 0);
        default: begin
          check("mv_bus", bus, mregs[ry]);
          if (op == OP_MV || !mz) mregs[rx] = mregs[ry];
        end
      endcase
      check("t1_done", done, 1);
      check("t1_z", z, mz);
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_reg(input int r, input logic [15:0] v);
    check("reg_model", mregs[r], v);
    exec(OP_MV, r, r, 16'h0);
  endtask

  task automatic exec32(input logic [10:0] instr, input logic [31:0] imm,
                        output logic [31:0] dbus, output int lat);
    din32 = 32'(instr);
    run32 = 1'b1;
    lat   = 0;
    dbus  = 32'h0;
    @(posedge clk); #1;
    run32 = 1'b0;
    din32 = imm;
    #1;
    for (int i = 1; i <= 6; i++) begin
      if (done32) begin
        lat  = i;
        dbus = bus32;
        break;
      end
      @(posedge clk); #2;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] b32;
    int          lat;
    resetn = 1'b0;
    run    = 1'b0;
    run32  = 1'b0;
    din    = 16'h1234;
    din32  = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("rst_done", done, 0);
    check("rst_z", z, 0);
    check("rst_bus", bus, 16'h1234);

    // Program 1: ADD with bus=8 in T3
    exec(OP_MVI, 0, 0, 16'h0005);
    exec(OP_MVI, 1, 0, 16'h0003);
    exec(OP_ADD, 0, 1, 16'h0);
    check("p1_r0", mregs[0], 16'h0008);
    check("p1_z", z, 0);
    expect_reg(0, 16'h0008);

    // Program 2: wrap to zero, conditional move
    exec(OP_MVI, 2, 0, 16'hFFFF);
    exec(OP_MVI, 3, 0, 16'h0001);
    exec(OP_ADD, 2, 3, 16'h0);
    check("p2_z", z, 1);
    exec(OP_MVNZ, 4, 3, 16'h0);
    expect_reg(4, 16'h0000);
    exec(OP_SUB, 3, 2, 16'h0);
    check("p2_z_sub", z, 0);
    exec(OP_MVNZ, 4, 3, 16'h0);
    expect_reg(4, 16'h0001);

    // Program 3: shift to MSB then AND to zero
    exec(OP_MVI, 5, 0, 16'h0001);
    exec(OP_MVI, 6, 0, 16'h000F);
    exec(OP_SLL, 5, 6, 16'h0);
    expect_reg(5, 16'h8000);
    exec(OP_AND, 5, 6, 16'h0);
    check("p3_z", z, 1);
    expect_reg(5, 16'h0000);

    // rx == ry and reserved opcode
    exec(OP_SUB, 1, 1, 16'h0);
    expect_reg(1, 16'h0000);
    exec(OP_MVI, 7, 0, 16'hBEEF);
    exec(OP_RSV, 7, 7, 16'h0);
    expect_reg(7, 16'hBEEF);

    for (int n = 0; n < 150; n++) begin
      exec(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           16'($urandom));
    end
    for (int r = 0; r < 8; r++) exec(OP_MV, r, r, 16'h0);

    // Reset in T2 of ADD R0,R1 aborts it
    exec(OP_MVI, 0, 0, 16'h0005);
    exec(OP_MVI, 1, 0, 16'h0003);
    run = 1'b1;
    din = 16'h0081;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    din    = 16'h5A5A;
    model_reset();
    #1;
    check("abort_done", done, 0);
    check("abort_bus", bus, 16'h5A5A);
    check("abort_z", z, 0);
    @(posedge clk); #1;
    check("abort_done2", done, 0);
    for (int r = 0; r < 8; r++) expect_reg(r, 16'h0000);
    run = 1'b0;

    // Wide build
    exec32({3'b001, 4'd15, 4'd0}, 32'h7FFF_FFFF, b32, lat);
    check("w_mvi_lat", lat, 1);
    check("w_mvi_bus", b32, 32'h7FFF_FFFF);
    exec32({3'b001, 4'd14, 4'd0}, 32'h0000_0001, b32, lat);
    check("w_mvi2_lat", lat, 1);
    exec32({3'b010, 4'd15, 4'd14}, 32'h0, b32, lat);
    check("w_add_lat", lat, 3);
    check("w_add_bus", b32, 32'h8000_0000);
    check("w_add_z", z32, 0);
    exec32({3'b000, 4'd15, 4'd15}, 32'h0, b32, lat);
    check("w_r15", b32, 32'h8000_0000);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
